// File: rtl/fmad_mul.sv
// fmad_mul - multiply front stage of the fused multiply-add path.
// Computes ope1*ope2 in IEEE-754 single precision over a fixed 3-stage
// pipeline. The addend (ope3) and the is_sub/is_neg control bits travel
// alongside the product, so they reach the add stage on the same cycle.
// Denormal inputs are flushed to zero. NaN inputs are treated as inf.
// No denormal results are produced. inf x zero returns the canonical qNaN.
//
// Ports:
//   clk, rstn          clock (rising edge), async active-low reset
//   clken              pipeline advance enable; low freezes all state
//   in_valid           qualifies ope1/ope2/ope3/is_sub/is_neg
//   ope1, ope2         FP32 multiplicand / multiplier
//   ope3               addend, passed through unmodified
//   is_sub, is_neg     control flags, passed through
//   out_valid          qualifies all outputs
//   prod               FP32 product (registered)
//   ope3_q, is_sub_q, is_neg_q   delayed pass-through fields
module fmad_mul #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clken,
  input  logic        in_valid,
  input  logic [31:0] ope1,
  input  logic [31:0] ope2,
  input  logic [31:0] ope3,
  input  logic        is_sub,
  input  logic        is_neg,
  output logic        out_valid,
  output logic [31:0] prod,
  output logic [31:0] ope3_q,
  output logic        is_sub_q,
  output logic        is_neg_q
);

  // The pipeline depth is fixed; the parameter only documents it.
  if (LATENCY != 3) begin : g_bad_latency
    $error("fmad_mul: LATENCY must be 3");
  end

  // S1: unpack / multiply
  logic               v1_q,     v1_d;
  logic               sign1_q,  sign1_d;
  logic signed [9:0]  exp1_q,   exp1_d;
  logic [47:0]        mul1_q,   mul1_d;
  logic               zero1_q,  zero1_d;
  logic               inf1_q,   inf1_d;

  // S2: normalize / round
  logic               v2_q,     v2_d;
  logic               sign2_q,  sign2_d;
  logic signed [9:0]  exp2_q,   exp2_d;
  logic [22:0]        mant2_q,  mant2_d;
  logic               zero2_q,  zero2_d;
  logic               inf2_q,   inf2_d;

  // S3: pack
  logic               v3_q;
  logic [31:0]        prod3_q,  prod3_d;

  // Pass-through delay lines
  logic [31:0]        ope3_1_q, ope3_2_q, ope3_3_q;
  logic [2:0]         sub_sr_q, neg_sr_q;

  logic [7:0]         ea, eb;
  logic               za, zb, ia, ib;

  always_comb begin
    ea      = ope1[30:23];
    eb      = ope2[30:23];
    za      = (ea == 8'd0);
    zb      = (eb == 8'd0);
    ia      = (ea == 8'hFF);
    ib      = (eb == 8'hFF);
    v1_d    = in_valid;
    sign1_d = ope1[31] ^ ope2[31];
    exp1_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    mul1_d  = 48'({1'b1, ope1[22:0]}) * 48'({1'b1, ope2[22:0]});
    zero1_d = za | zb;
    inf1_d  = ia | ib;
  end

  logic [22:0] mant_n;
  logic        guard, sticky, round_up, carry;
  logic [22:0] mant_r;
  logic signed [9:0] exp_n;

  always_comb begin
    if (mul1_q[47]) begin
      mant_n = mul1_q[46:24];
      guard  = mul1_q[23];
      sticky = |mul1_q[22:0];
      exp_n  = exp1_q + 10'sd1;
    end else begin
      mant_n = mul1_q[45:23];
      guard  = mul1_q[22];
      sticky = |mul1_q[21:0];
      exp_n  = exp1_q;
    end
    round_up          = guard & (sticky | mant_n[0]);
    {carry, mant_r}   = {1'b0, mant_n} + 24'(round_up);
    v2_d    = v1_q;
    sign2_d = sign1_q;
    mant2_d = mant_r;                       // wraps to 0 on carry
    exp2_d  = carry ? (exp_n + 10'sd1) : exp_n;
    zero2_d = zero1_q;
    inf2_d  = inf1_q;
  end

  always_comb begin
    if (inf2_q && zero2_q)
      prod3_d = 32'h7FC0_0000;
    else if (inf2_q)
      prod3_d = {sign2_q, 8'hFF, 23'd0};
    else if (zero2_q)
      prod3_d = {sign2_q, 31'd0};
    else if (exp2_q >= 10'sd255)
      prod3_d = {sign2_q, 8'hFF, 23'd0};
    else if (exp2_q <= 10'sd0)
      prod3_d = {sign2_q, 31'd0};
    else
      prod3_d = {sign2_q, exp2_q[7:0], mant2_q};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q     <= 1'b0;
      sign1_q  <= 1'b0;
      exp1_q   <= '0;
      mul1_q   <= '0;
      zero1_q  <= 1'b0;
      inf1_q   <= 1'b0;
      v2_q     <= 1'b0;
      sign2_q  <= 1'b0;
      exp2_q   <= '0;
      mant2_q  <= '0;
      zero2_q  <= 1'b0;
      inf2_q   <= 1'b0;
      v3_q     <= 1'b0;
      prod3_q  <= '0;
      ope3_1_q <= '0;
      ope3_2_q <= '0;
      ope3_3_q <= '0;
      sub_sr_q <= '0;
      neg_sr_q <= '0;
    end else if (clken) begin
      v1_q     <= v1_d;
      sign1_q  <= sign1_d;
      exp1_q   <= exp1_d;
      mul1_q   <= mul1_d;
      zero1_q  <= zero1_d;
      inf1_q   <= inf1_d;
      v2_q     <= v2_d;
      sign2_q  <= sign2_d;
      exp2_q   <= exp2_d;
      mant2_q  <= mant2_d;
      zero2_q  <= zero2_d;
      inf2_q   <= inf2_d;
      v3_q     <= v2_q;
      prod3_q  <= prod3_d;
      ope3_1_q <= ope3;
      ope3_2_q <= ope3_1_q;
      ope3_3_q <= ope3_2_q;
      sub_sr_q <= {sub_sr_q[1:0], is_sub};
      neg_sr_q <= {neg_sr_q[1:0], is_neg};
    end
  end

  assign out_valid = v3_q;
  assign prod      = prod3_q;
  assign ope3_q    = ope3_3_q;
  assign is_sub_q  = sub_sr_q[2];
  assign is_neg_q  = neg_sr_q[2];

endmodule

// File: tb/tb_fmad_mul.sv
// Scoreboard bench for fmad_mul: the driver pushes hand-computed expected
// results; an independent monitor pops and compares whenever out_valid is
// seen on an enabled edge.
module tb_fmad_mul;

  logic        clk = 1'b0;
  logic        rstn, clken, in_valid, is_sub, is_neg;
  logic [31:0] ope1, ope2, ope3;
  logic        out_valid, is_sub_q, is_neg_q;
  logic [31:0] prod, ope3_q;

  fmad_mul #(.LATENCY(3)) dut (
    .clk(clk), .rstn(rstn), .clken(clken), .in_valid(in_valid),
    .ope1(ope1), .ope2(ope2), .ope3(ope3), .is_sub(is_sub), .is_neg(is_neg),
    .out_valid(out_valid), .prod(prod), .ope3_q(ope3_q),
    .is_sub_q(is_sub_q), .is_neg_q(is_neg_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] prod;
    logic [31:0] ope3;
    logic        sub;
    logic        neg;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, expv);
    end
  endtask

  // Monitor
  logic        mon_en, mon_rst, prev_v;
  logic [31:0] prev_prod;
  exp_t        mon_e;
  initial begin prev_v = 1'b0; prev_prod = '0; end

  always @(posedge clk) begin
    mon_en  = clken;
    mon_rst = rstn;
    #1;
    if (mon_rst === 1'b1) begin
      if (mon_en !== 1'b1) begin
        chk("hold_valid", {31'd0, out_valid}, {31'd0, prev_v});
        chk("hold_prod", prod, prev_prod);
      end else if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {31'd0, out_valid}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("prod", prod, mon_e.prod);
          chk("ope3_q", ope3_q, mon_e.ope3);
          chk("is_sub_q", {31'd0, is_sub_q}, {31'd0, mon_e.sub});
          chk("is_neg_q", {31'd0, is_neg_q}, {31'd0, mon_e.neg});
        end
      end
    end
    prev_v    = out_valid;
    prev_prod = prod;
  end

  // Driver helpers (all called right after a falling edge)
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic s, input logic n, input logic [31:0] expp);
    exp_t e;
    ope1 = a; ope2 = b; ope3 = c; is_sub = s; is_neg = n; in_valid = 1'b1;
    e.prod = expp; e.ope3 = c; e.sub = s; e.neg = n;
    sb.push_back(e);
  endtask

  task automatic bubble();
    in_valid = 1'b0;
    ope1 = 32'hDEAD_BEEF; ope2 = 32'h1234_5678; ope3 = 32'h0BAD_F00D;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_remaining", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_prod"}, prod, 32'd0);
    chk({tag, "_ope3_q"}, ope3_q, 32'd0);
    chk({tag, "_flags"}, {30'd0, is_sub_q, is_neg_q}, 32'd0);
  endtask

  localparam int NV = 10;
  logic [31:0] va [NV] = '{32'h4000_0000, 32'h3FC0_0000, 32'h7F00_0000, 32'h0080_0000,
                           32'h8000_0001, 32'h7F80_0000, 32'h3F80_0001, 32'h3FFF_FFFF,
                           32'h7FC0_0000, 32'hFF80_0000};
  logic [31:0] vb [NV] = '{32'h4040_0000, 32'hBFC0_0000, 32'h4000_0000, 32'h0080_0000,
                           32'h3F80_0000, 32'h0000_0000, 32'h3F80_0001, 32'h3FFF_FFFF,
                           32'hC000_0000, 32'h8000_0000};
  logic [31:0] vx [NV] = '{32'h4000_0000 * 0 + 32'h40C0_0000, 32'hC010_0000, 32'h7F80_0000,
                           32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000, 32'h3F80_0002,
                           32'h407F_FFFE, 32'hFF80_0000, 32'h7FC0_0000};

  initial begin
    rstn = 1'b0; clken = 1'b1; in_valid = 1'b0;
    ope1 = '0; ope2 = '0; ope3 = '0; is_sub = 1'b0; is_neg = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    rstn = 1'b1;

    // Directed vectors, back-to-back
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (i == 1) issue(va[i], vb[i], 32'h1234_5678, 1'b1, 1'b0, vx[i]);
      else        issue(va[i], vb[i], 32'hA500_0000 + 32'(i), i[0], i[1], vx[i]);
    end
    @(negedge clk); bubble();
    drain();

    // Stall: A, B, two cycles clken=0, then C
    @(negedge clk); issue(32'h4000_0000, 32'h4000_0000, 32'h0000_00AA, 1'b0, 1'b1, 32'h4080_0000);
    @(negedge clk); issue(32'h4040_0000, 32'h4040_0000, 32'h0000_00BB, 1'b1, 1'b1, 32'h4110_0000);
    @(negedge clk); bubble(); clken = 1'b0;
    @(negedge clk);
    @(negedge clk); clken = 1'b1;
    issue(32'hC000_0000, 32'h4040_0000, 32'h0000_00CC, 1'b1, 1'b0, 32'hC0C0_0000);
    @(negedge clk); bubble();
    drain();

    // Reset mid-flight
    @(negedge clk); issue(32'h4000_0000, 32'h4040_0000, 32'h1111_1111, 1'b1, 1'b1, 32'h40C0_0000);
    @(negedge clk); issue(32'h3F80_0000, 32'h3F80_0000, 32'h2222_2222, 1'b1, 1'b0, 32'h3F80_0000);
    @(negedge clk); bubble(); rstn = 1'b0; sb.delete();
    #1 chk_reset_outs("midreset");
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_idle", {31'd0, out_valid}, 32'd0);
    end
    issue(32'h4080_0000, 32'h4080_0000, 32'h3333_3333, 1'b0, 1'b1, 32'h4180_0000);
    @(negedge clk); bubble();
    chk("latency_e1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("latency_e2", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("latency_e3", {31'd0, out_valid}, 32'd1);
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fmad_mul.md
Name: fmad_mul

Overview:
- Multiply front stage of the fused multiply-add path: computes ope1*ope2 in IEEE-754 single precision.
- Carries the addend (ope3) and the is_sub/is_neg control bits alongside the product, so the pair arrives aligned.
- Its outputs drive the add stage directly: prod feeds the first add operand (negated by is_neg), ope3_q feeds the second (negated by is_sub).
- Fixed 3-stage pipeline with a global clock enable, matching the add stage's clken convention.

Parameters:
- LATENCY, 3, pipeline depth in enabled cycles; informational only, the design is fixed at 3.

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- clken  in  1  pipeline advance enable; low freezes all state
- in_valid  in  1  qualifies ope1/ope2/ope3/is_sub/is_neg
- ope1  in  32  multiplicand, FP32
- ope2  in  32  multiplier, FP32
- ope3  in  32  addend, passed through unmodified
- is_sub  in  1  negate-addend flag, passed through
- is_neg  in  1  negate-product flag, passed through
- out_valid  out  1  qualifies all outputs below
- prod  out  32  FP32 product, registered
- ope3_q  out  32  delayed ope3
- is_sub_q  out  1  delayed is_sub
- is_neg_q  out  1  delayed is_neg

Behaviour:
- Interface: one clock (clk); reset rstn is asynchronous and active-low.
- Reset: rstn low clears every pipeline register, including all valid bits.
  - Outputs during reset: out_valid=0, prod=0, ope3_q=0, is_sub_q=0, is_neg_q=0.
  - Reset mid-operation discards all in-flight items; no partial result appears after release.
- Advance rules:
  - All stages advance only on a rising edge with clken=1.
  - clken=0 holds every register, including out_valid and data.
  - No backpressure beyond clken.
  - Latency is exactly 3 enabled edges from input capture to output.
  - Throughput is one item per enabled cycle.
- Valid handling: a valid bit travels with each item; data registers load regardless of in_valid, so bubbles are allowed.
- S1 (unpack/multiply):
  - sign = s1 ^ s2.
  - Exponent field 0 counts as zero: denormals are flushed to zero on input.
  - Exponent field 255 counts as inf: the mantissa is ignored and NaN inputs are treated as inf.
  - Register the 10-bit signed exponent e = ea + eb - 127.
  - Register the 48-bit product of {1,ma} x {1,mb}.
  - Register the zero/inf flags.
- S2 (normalize/round):
  - If p[47]=1: mant = p[46:24], guard = p[23], sticky = OR(p[22:0]), e = e+1.
  - Else: mant = p[45:23], guard = p[22], sticky = OR(p[21:0]).
  - Round to nearest even: increment when guard & (sticky | mant[0]).
  - If the increment overflows the mantissa: mant = 0 and e = e+1.
- S3 (pack and special cases, in priority order):
  1. inf x zero: prod = 0x7FC00000.
  2. Either operand inf: signed inf.
  3. Either operand zero: signed zero.
  4. e >= 255: signed inf, i.e. {sign, 0xFF, 0}.
  5. e <= 0: signed zero, no denormal output.
  6. Otherwise: {sign, e[7:0], mant}.
- Pass-through fields (ope3, is_sub, is_neg) are delayed through 3 registers in lockstep with the product.

Test Plan:
- 0x40000000 x 0x40400000 (2.0 x 3.0), in_valid=1, clken=1 -> 3 edges later out_valid=1, prod=0x40C00000.
- 0x3FC00000 x 0xBFC00000, with ope3=0x12345678, is_sub=1, is_neg=0 -> prod=0xC0100000 (-2.25), ope3_q=0x12345678, is_sub_q=1, is_neg_q=0, all aligned on the same cycle.
- Special values:
  - 0x7F000000 x 0x40000000 -> 0x7F800000 (overflow to inf).
  - 0x00800000 x 0x00800000 -> 0x00000000 (underflow to zero).
  - 0x80000001 x 0x3F800000 -> 0x80000000 (denormal input flushed, sign kept).
  - 0x7F800000 x 0x00000000 -> 0x7FC00000.
- Rounding:
  - 0x3F800001 x 0x3F800001 -> 0x3F800002.
  - 0x3FFFFFFF x 0x3FFFFFFF -> 0x407FFFFE (sticky set, no increment).
- Back-to-back issue of items A,B,C on consecutive cycles, with clken=0 for 2 cycles after B is issued -> outputs hold unchanged during the stall; results arrive A,B,C in order, each on consecutive enabled edges, with no duplicates.
- Issue 2 items, assert rstn=0 for 1 cycle mid-flight, release -> out_valid stays 0 until a new item is issued; the new item's result appears 3 enabled edges later.
